// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared prescaler and period counter (edge- or
// center-aligned) driving CHANNELS compare outputs with double-buffered duty registers.
module pwm_multi #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             enable,
    input  logic                                             mode,
    input  logic [PRESCALE_W-1:0]                            prescale,
    input  logic [WIDTH-1:0]                                 period,
    input  logic                                             wr_en,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_ch,
    input  logic [WIDTH-1:0]                                 wr_duty,
    input  logic [CHANNELS-1:0]                              polarity,
    output logic [CHANNELS-1:0]                              pwm_o,
    output logic                                             period_start
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [PRESCALE_W-1:0] presc_cnt;
    logic [WIDTH-1:0]      cnt;
    logic                  dir_down;
    logic [WIDTH-1:0]      act_period;
    logic                  act_mode;
    logic [WIDTH-1:0]      shadow   [CHANNELS];
    logic [WIDTH-1:0]      act_duty [CHANNELS];

    logic                  tick;
    logic                  boundary;
    logic [WIDTH-1:0]      cnt_next;
    logic                  dir_next;

    assign tick = enable && (presc_cnt == prescale);

    // Next counter value/direction if a tick occurs; the counter never runs past act_period.
    always_comb begin
        cnt_next = cnt;
        dir_next = dir_down;
        if (act_period == '0) begin
            cnt_next = '0;
            dir_next = 1'b0;
        end else if (!act_mode) begin
            cnt_next = (cnt >= act_period) ? '0 : cnt + 1'b1;
        end else if (!dir_down) begin
            if (cnt >= act_period) begin
                cnt_next = act_period - 1'b1;
                dir_next = 1'b1;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end else begin
            cnt_next = (cnt == '0) ? '0 : cnt - 1'b1;
        end
    end

    assign boundary = tick && (cnt_next == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt    <= '0;
            cnt          <= '0;
            dir_down     <= 1'b0;
            act_period   <= '0;
            act_mode     <= 1'b0;
            pwm_o        <= '0;
            period_start <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i]   <= '0;
                act_duty[i] <= '0;
            end
        end else begin
            period_start <= boundary;

            if (!enable) begin
                // Idle: keep active settings tracking the inputs so the first period uses them.
                presc_cnt  <= '0;
                cnt        <= '0;
                dir_down   <= 1'b0;
                act_period <= period;
                act_mode   <= mode;
                for (int i = 0; i < CHANNELS; i++) begin
                    act_duty[i] <= shadow[i];
                end
            end else begin
                presc_cnt <= (presc_cnt >= prescale) ? '0 : presc_cnt + 1'b1;
                if (tick) begin
                    cnt      <= cnt_next;
                    dir_down <= boundary ? 1'b0 : dir_next;
                end
                if (boundary) begin
                    act_period <= period;
                    act_mode   <= mode;
                    for (int i = 0; i < CHANNELS; i++) begin
                        act_duty[i] <= shadow[i];
                    end
                end
            end

            // An index at or above CHANNELS matches no slot, so the write is dropped.
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en && (wr_ch == CH_W'(i))) begin
                    shadow[i] <= wr_duty;
                end
                pwm_o[i] <= (enable && (cnt < act_duty[i])) ^ polarity[i];
            end
        end
    end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel, parametrised PWM generator; the successor of the single 8-bit PWM. All channels share one prescaler and one period counter with a programmable period and selectable edge- or center-aligned counting. Each channel has its own double-buffered duty register and output polarity. Sits between the register/config front-end and the output pads. Duty, period and mode updates take effect only at a period boundary, so no output ever shows a glitched cycle.

## Interface
Parameters:
- WIDTH, 8, counter, period and duty width
- CHANNELS, 4, number of PWM outputs (≥1)
- PRESCALE_W, 8, prescaler compare width

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- enable  in  1  1 = run; 0 = hold counter/prescaler at 0, outputs inactive
- mode  in  1  0 = edge-aligned, 1 = center-aligned (latched at boundary)
- prescale  in  PRESCALE_W  tick every prescale+1 clk cycles
- period  in  WIDTH  counter top value P (latched at boundary)
- wr_en  in  1  write shadow duty register
- wr_ch  in  max(1,$clog2(CHANNELS))  channel index for the write
- wr_duty  in  WIDTH  duty value to write
- polarity  in  CHANNELS  per-channel output inversion, applied live
- pwm_o  out  CHANNELS  registered PWM outputs
- period_start  out  1  one-cycle pulse at start of each period

## Operation
- Prescaler: presc_cnt counts 0..prescale. tick = enable && presc_cnt==prescale, then presc_cnt returns to 0. prescale=0 gives a tick every cycle.
- Edge mode counter, advances on tick: cnt 0,1,…,P,0,…; period length P+1 ticks.
- Center mode counter, advances on tick:
  - up: cnt+1 until cnt==P, then direction flips to down.
  - down: cnt−1 until cnt reaches 0.
  - Sequence 0,1,…,P,P−1,…,1,0; period length 2P ticks.
- Boundary = a tick on which the next cnt is 0. If act_period==0, cnt stays 0 and every tick is a boundary in both modes.
- At a boundary:
  - act_duty[i] ← shadow[i] for all channels.
  - act_period ← period, act_mode ← mode.
  - Direction is forced to up.
- enable=0:
  - presc_cnt=0, cnt=0, direction up.
  - act_* load continuously from shadow/period/mode, so the first period after enable uses current values.
- Shadow write: on wr_en, shadow[wr_ch] ← wr_duty. A wr_ch ≥ CHANNELS write is ignored, with no side effect.
- Write on the same cycle as a boundary: the boundary loads the old shadow value; the new value applies from the next boundary.
- Compare: raw[i] = enable && (cnt < act_duty[i]).
  - duty 0 → always low.
  - duty > P → always high, in both modes.
  - Edge mode high time = duty ticks out of P+1.
  - Center mode high time = 2·duty−1 ticks out of 2P, symmetric about cnt==0 (for 0<duty≤P).
- Output: pwm_o[i] ← raw[i] ^ polarity[i], registered.
- Arithmetic: unsigned, WIDTH bits, no wrap past P; P = 2^WIDTH−1 is legal.
- Reset mid-operation: all state returns to reset values on the next edge; shadow contents are lost.

## Timing
- Reset values: presc_cnt=0, cnt=0, direction up, shadow=0, act_duty=0, act_period=0, act_mode=0, pwm_o=0, period_start=0.
- From the first cycle after reset, pwm_o = polarity while enable=0.
- pwm_o reflects the cnt value with 1 clk latency.
- period_start is high the single clk cycle in which cnt==0 is first present after a boundary. It is not asserted while enable=0.
- enable 0→1 with prescale=0: first tick on that same edge, so cnt=1 one cycle later; period_start does not fire for this initial 0.
- polarity change is visible on pwm_o 1 clk later.

## Test plan
- Edge mode, CH0: WIDTH=8, prescale=0, period=9, duty=3, enable=1 → pwm_o[0] high 3 clk, low 7 clk, repeating every 10 clk; period_start pulses every 10 clk.
- Center mode, period=4, duty=2 → counter 0,1,2,3,4,3,2,1; pwm_o high 3 of 8 ticks, centered on cnt=0.
- Double buffering: while running with duty=3, write duty=7 mid-period → old waveform until the next period_start, then 7-high.
- Write coinciding with a boundary → the new duty appears only one full period later.
- Limits:
  - duty=0 → constant low.
  - duty=period+1 and duty=255 with period=9 → constant high.
  - polarity[0]=1 inverts each of these.
  - wr_ch=CHANNELS (out of range) changes nothing.
- Prescale=2, period=1, edge mode, duty=1 → output high 3 clk, low 3 clk.
- rst mid-period → pwm_o=0 next cycle, shadow cleared, output stays at the polarity level after enable.
